enc_8x3_seq: RTL and testbench



---
 rtl/enc_pkg.sv | 23 ++
 rtl/prio_enc_8x3.sv | 14 +
 rtl/enc_8x3_seq.sv | 86 ++++++++
 tb/tb_enc_8x3_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants, state type and lowest-set-bit helper for the 8-to-3 encoders.
// Used by enc_8x3_seq (optional ENC_LAST_EN build) and prio_enc_8x3.
package enc_pkg;

  localparam int ENC_N = 8;
  localparam int ENC_W = 3;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  // Scanning from the top down lets the lowest set bit overwrite any higher one.
  function automatic logic [ENC_W-1:0] lowest_set(input logic [ENC_N-1:0] vec);
    logic [ENC_W-1:0] idx;
    idx = '0;
    for (int i = ENC_N - 1; i >= 0; i--) begin
      if (vec[i]) idx = ENC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational 8-to-3 priority encoder, lowest index wins.
// found is low for an all-zero vector, in which case idx is 0.
module prio_enc_8x3
  import enc_pkg::*;
(
  input  logic [ENC_N-1:0] vec,
  output logic             found,
  output logic [ENC_W-1:0] idx
);

  assign found = |vec;
  assign idx   = lowest_set(vec);

endmodule

// File: rtl/enc_8x3_seq.sv
// Sequential 8-to-3 encoder: emits the index of every set bit of an accepted vector,
// lowest first, one per output handshake. Define ENC_LAST_EN to add the out_last port.
module enc_8x3_seq
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ENC_N-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ENC_W-1:0] out_idx,
  output logic             busy,
  output logic             zero
`ifdef ENC_LAST_EN
  ,
  output logic             out_last
`endif
);

  state_t           state, state_next;
  logic [ENC_N-1:0] pending, pending_next;
  logic             zero_next;
  logic             found;
  logic [ENC_W-1:0] lead_idx;

  prio_enc_8x3 u_prio (
    .vec   (pending),
    .found (found),
    .idx   (lead_idx)
  );

  // out_idx comes straight off the pending register, so a stalled index stays put.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    zero_next    = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    out_idx      = '0;
    case (state)
      IDLE: begin
        in_ready = En;
        if (in_valid && En) begin
          if (in_vec != '0) begin
            pending_next = in_vec;
            state_next   = SCAN;
          end else begin
            zero_next = 1'b1;
          end
        end
      end
      SCAN: begin
        busy      = 1'b1;
        out_valid = found;
        if (found) out_idx = lead_idx;
        if (found && out_ready) begin
          pending_next = pending & ~(ENC_N'(1) << lead_idx);
          if (pending_next == '0) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      zero    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      zero    <= zero_next;
    end
  end

`ifdef ENC_LAST_EN
  // Exactly one bit left means the index on the output is the vector's final one.
  assign out_last = out_valid && ((pending & (pending - ENC_N'(1))) == '0);
`endif

endmodule

// File: tb/tb_enc_8x3_seq.sv
// Directed and scoreboarded random bench for enc_8x3_seq.
// Also checks out_last when compiled with ENC_LAST_EN.
module tb_enc_8x3_seq;
  import enc_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             En;
  logic             in_valid;
  logic             in_ready;
  logic [ENC_N-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [ENC_W-1:0] out_idx;
  logic             busy;
  logic             zero;
`ifdef ENC_LAST_EN
  logic             out_last;
`endif

  int compared   = 0;
  int mismatched = 0;

  enc_8x3_seq dut (
    .clk       (clk),
    .rst       (rst),
    .En        (En),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .busy      (busy),
    .zero      (zero)
`ifdef ENC_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] vec, input logic ready);
    En        = en;
    in_valid  = valid;
    in_vec    = vec;
    out_ready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          expq[$];
  logic [7:0]  v;
  logic        r;
  int          guard;
  logic [7:0]  sparse_idx [3];

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_out_idx", out_idx, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Full vector: 0..7 on consecutive cycles.
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("ff_valid", out_valid, 1);
      checkOutput("ff_idx", out_idx, i);
      checkOutput("ff_busy", busy, 1);
      checkOutput("ff_in_ready", in_ready, 0);
`ifdef ENC_LAST_EN
      checkOutput("ff_last", out_last, (i == 7) ? 1 : 0);
`endif
      tick();
    end
    checkOutput("ff_done_valid", out_valid, 0);
    checkOutput("ff_done_in_ready", in_ready, 1);
    checkOutput("ff_done_idx", out_idx, 0);

    // Sparse vector with three cycles of backpressure.
    sparse_idx[0] = 8'd2;
    sparse_idx[1] = 8'd5;
    sparse_idx[2] = 8'd7;
    applyStimulus(1'b1, 1'b1, 8'b1010_0100, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("sp_stall_valid", out_valid, 1);
      checkOutput("sp_stall_idx", out_idx, 2);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("sp_valid", out_valid, 1);
      checkOutput("sp_idx", out_idx, sparse_idx[i]);
      tick();
    end
    checkOutput("sp_done_valid", out_valid, 0);

    // Zero vector: one-cycle zero pulse, no output.
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("zv_zero", zero, 1);
    checkOutput("zv_out_valid", out_valid, 0);
    checkOutput("zv_busy", busy, 0);
    checkOutput("zv_in_ready", in_ready, 1);
    tick();
    checkOutput("zv_zero_drop", zero, 0);

    // Enable low blocks acceptance.
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b1);
    #1;
    checkOutput("en_in_ready", in_ready, 0);
    tick();
    tick();
    checkOutput("en_out_valid", out_valid, 0);
    checkOutput("en_busy", busy, 0);
    checkOutput("en_zero", zero, 0);

    // Enable dropped mid-scan does not stop it.
    applyStimulus(1'b1, 1'b1, 8'h81, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("en81_idx0", out_idx, 0);
    checkOutput("en81_valid0", out_valid, 1);
    tick();
    checkOutput("en81_idx7", out_idx, 7);
    checkOutput("en81_valid7", out_valid, 1);
    tick();
    checkOutput("en81_done", out_valid, 0);
    checkOutput("en81_in_ready", in_ready, 0);

    // Asynchronous reset mid-scan discards the remaining indices.
    applyStimulus(1'b1, 1'b1, 8'hF0, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("mr_pre_idx", out_idx, 4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mr_out_valid", out_valid, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_zero", zero, 0);
    checkOutput("mr_out_idx", out_idx, 0);
    tick();
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("mr_post_valid", out_valid, 0);
    checkOutput("mr_post_in_ready", in_ready, 1);

    // Random regression against a queue of expected indices.
    for (int n = 0; n < 1000; n++) begin
      v = 8'($urandom_range(0, 255));
      checkOutput("rnd_idle_ready", in_ready, 1);
      applyStimulus(1'b1, 1'b1, v, 1'b0);
      tick();
      in_valid = 1'b0;
      expq.delete();
      for (int i = 0; i < 8; i++) if (v[i]) expq.push_back(i);
      if (v == 8'h00) begin
        checkOutput("rnd_zero", zero, 1);
        checkOutput("rnd_zero_valid", out_valid, 0);
        tick();
      end else begin
        guard = 0;
        while (expq.size() > 0 && guard < 100) begin
          checkOutput("rnd_valid", out_valid, 1);
          r = 1'($urandom_range(0, 1));
          out_ready = r;
          if (r) begin
            checkOutput("rnd_idx", out_idx, expq[0]);
`ifdef ENC_LAST_EN
            checkOutput("rnd_last", out_last, (expq.size() == 1) ? 1 : 0);
`endif
            void'(expq.pop_front());
          end
          tick();
          guard++;
        end
        checkOutput("rnd_drain", expq.size(), 0);
        out_ready = 1'b0;
        checkOutput("rnd_done", out_valid, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
